// File: rtl/fetch_ctrl.sv
// fetch_ctrl - instruction fetch sequencer between the 16-entry instruction
// ROM and decode. It owns the fetch PC, registers the combinational ROM word
// into a single-entry buffer, and hands it to decode over a valid/ready pair.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start_i            IDLE -> RUN, fetch from RESET_PC
//   halt_i             RUN -> HALT (drains the buffered instruction)
//   rom_addr_o         fetch PC, drives the ROM address
//   rom_inst_i         combinational ROM data at rom_addr_o
//   inst_o, pc_o       buffered instruction and the address it came from
//   inst_valid_o       buffer valid
//   inst_ready_i       decode accepts inst_o this cycle
//   br_taken_i         redirect fetch to br_target_i and flush the buffer
//   br_target_i        redirect address
//   state_o            00 IDLE, 01 RUN, 10 HALT
//   fetch_cnt_o        instructions loaded into the buffer, saturates at 255
module fetch_ctrl #(
  parameter int unsigned        ADDR_W   = 4,
  parameter int unsigned        INST_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic [1:0]        state_o,
  output logic [7:0]        fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fpc_q, fpc_d;     // fetch PC
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   bpc_q, bpc_d;     // PC of the buffered instruction
  logic                valid_q, valid_d;
  logic [7:0]          cnt_q, cnt_d;

  logic xfer, buf_free;
  logic do_start, do_branch, do_load;

  assign xfer     = valid_q & inst_ready_i;
  assign buf_free = ~valid_q | xfer;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; branch beats halt in RUN, HALT exits only on reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (!br_taken_i && halt_i) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    do_start  = 1'b0;
    do_branch = 1'b0;
    do_load   = 1'b0;
    case (state_q)
      S_IDLE: do_start = start_i;
      S_RUN: begin
        do_branch = br_taken_i;
        do_load   = !br_taken_i && !halt_i && buf_free;
      end
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    fpc_d   = fpc_q;
    inst_d  = inst_q;
    bpc_d   = bpc_q;
    cnt_d   = cnt_q;
    // A transfer always consumes the buffer, including on a flush edge
    valid_d = valid_q & ~xfer;
    if (do_start) begin
      fpc_d = RESET_PC;
    end else if (do_branch) begin
      fpc_d   = br_target_i;
      valid_d = 1'b0;
    end else if (do_load) begin
      inst_d  = rom_inst_i;
      bpc_d   = fpc_q;
      valid_d = 1'b1;
      fpc_d   = fpc_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q   <= RESET_PC;
      inst_q  <= '0;
      bpc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fpc_q   <= fpc_d;
      inst_q  <= inst_d;
      bpc_q   <= bpc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr_o   = fpc_q;
  assign inst_o       = inst_q;
  assign pc_o         = bpc_q;
  assign inst_valid_o = valid_q;
  assign state_o      = state_q;
  assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. ROM word k = 16'hA000 + k. Each vector
// drives inputs, takes one rising edge, then compares all outputs 1ns later.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, start_i, halt_i, inst_ready_i, br_taken_i;
  logic [3:0]  br_target_i, rom_addr_o, pc_o;
  logic [15:0] rom_inst_i, inst_o;
  logic        inst_valid_o;
  logic [1:0]  state_o;
  logic [7:0]  fetch_cnt_o;

  always #5 clk = ~clk;

  assign rom_inst_i = 16'hA000 + {12'h000, rom_addr_o};

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .halt_i(halt_i),
    .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
    .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .br_taken_i(br_taken_i),
    .br_target_i(br_target_i), .state_o(state_o), .fetch_cnt_o(fetch_cnt_o)
  );

  typedef struct {
    logic        rst, start, halt, ready, br;
    logic [3:0]  tgt;
    logic [1:0]  e_state;
    logic        e_valid;
    logic [15:0] e_inst;
    logic [3:0]  e_pc, e_addr;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(logic r, logic s, logic h, logic rd, logic b,
                              logic [3:0] t, logic [1:0] es, logic ev,
                              logic [15:0] ei, logic [3:0] ep, logic [3:0] ea,
                              logic [7:0] ec);
    vec_t v;
    v.rst = r; v.start = s; v.halt = h; v.ready = rd; v.br = b; v.tgt = t;
    v.e_state = es; v.e_valid = ev; v.e_inst = ei; v.e_pc = ep;
    v.e_addr = ea; v.e_cnt = ec;
    vq.push_back(v);
  endfunction

  task automatic drive(logic r, logic s, logic h, logic rd, logic b, logic [3:0] t);
    rst = r; start_i = s; halt_i = h; inst_ready_i = rd; br_taken_i = b; br_target_i = t;
  endtask

  task automatic chk(string nm, logic [1:0] es, logic ev, logic [15:0] ei,
                     logic [3:0] ep, logic [3:0] ea, logic [7:0] ec);
    n_vec++;
    if ({state_o, inst_valid_o, inst_o, pc_o, rom_addr_o, fetch_cnt_o} !==
        {es, ev, ei, ep, ea, ec}) begin
      n_err++;
      $display("FAIL %s: got st=%b v=%b inst=%h pc=%0d addr=%0d cnt=%0d, exp st=%b v=%b inst=%h pc=%0d addr=%0d cnt=%0d",
               nm, state_o, inst_valid_o, inst_o, pc_o, rom_addr_o, fetch_cnt_o,
               es, ev, ei, ep, ea, ec);
    end
  endtask

  initial begin
    //   rst s h rdy br tgt   st    v  inst      pc  addr cnt
    // reset, then IDLE ignores halt/branch
    add(1, 0,0,1, 0, 0,  2'b00, 0, 16'h0000, 0,  0,  0);
    add(1, 0,0,1, 0, 0,  2'b00, 0, 16'h0000, 0,  0,  0);
    add(0, 0,1,1, 1, 5,  2'b00, 0, 16'h0000, 0,  0,  0);
    // start: RUN with empty buffer, then one load per cycle
    add(0, 1,0,1, 0, 0,  2'b01, 0, 16'h0000, 0,  0,  0);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA000, 0,  1,  1);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA001, 1,  2,  2);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA002, 2,  3,  3);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA003, 3,  4,  4);
    // backpressure: 4 stalled cycles hold A003/3, addr 4
    for (int i = 0; i < 4; i++)
      add(0, 0,0,0, 0, 0, 2'b01, 1, 16'hA003, 3,  4,  4);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA004, 4,  5,  5);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA005, 5,  6,  6);
    // branch with transfer: flush, bubble, then target
    add(0, 0,0,1, 1, 9,  2'b01, 0, 16'hA005, 5,  9,  6);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA009, 9,  10, 7);
    // branch and halt together: branch wins, stay RUN
    add(0, 0,1,1, 1, 9,  2'b01, 0, 16'hA009, 9,  9,  7);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA009, 9,  10, 8);
    // run through the wrap 15 -> 0
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA00A, 10, 11, 9);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA00B, 11, 12, 10);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA00C, 12, 13, 11);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA00D, 13, 14, 12);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA00E, 14, 15, 13);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA00F, 15, 0,  14);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA000, 0,  1,  15);
    add(0, 0,0,1, 0, 0,  2'b01, 1, 16'hA001, 1,  2,  16);
    // branch to 6, load A006 with ready low
    add(0, 0,0,1, 1, 6,  2'b01, 0, 16'hA001, 1,  6,  16);
    add(0, 0,0,0, 0, 0,  2'b01, 1, 16'hA006, 6,  7,  17);
    // halt while A006 held: drains once, addr frozen at 7
    add(0, 0,1,0, 0, 0,  2'b10, 1, 16'hA006, 6,  7,  17);
    add(0, 0,0,0, 0, 0,  2'b10, 1, 16'hA006, 6,  7,  17);
    add(0, 0,0,1, 0, 0,  2'b10, 0, 16'hA006, 6,  7,  17);
    // start/branch ignored in HALT
    add(0, 1,0,1, 1, 3,  2'b10, 0, 16'hA006, 6,  7,  17);
    add(0, 0,0,1, 0, 0,  2'b10, 0, 16'hA006, 6,  7,  17);
    // reset leaves HALT
    add(1, 0,0,1, 0, 0,  2'b00, 0, 16'h0000, 0,  0,  0);

    drive(1, 0, 0, 0, 0, 0);
    #1;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].start, vq[i].halt, vq[i].ready, vq[i].br, vq[i].tgt);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), vq[i].e_state, vq[i].e_valid, vq[i].e_inst,
          vq[i].e_pc, vq[i].e_addr, vq[i].e_cnt);
    end

    // Saturation: 300 loads from reset, count clamps at 255
    drive(0, 1, 0, 1, 0, 0);
    @(posedge clk); #1;
    chk("sat_start", 2'b01, 1'b0, 16'h0000, 4'd0, 4'd0, 8'd0);
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      logic [3:0] p;
      p = 4'(k - 1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d", k), 2'b01, 1'b1, 16'hA000 + {12'h000, p}, p,
          4'(k), (k > 255) ? 8'd255 : 8'(k));
    end

    // Reset mid-run discards the buffered instruction
    drive(1, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    chk("rst_mid_run", 2'b00, 1'b0, 16'h0000, 4'd0, 4'd0, 8'd0);
    drive(0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    chk("idle_after_rst", 2'b00, 1'b0, 16'h0000, 4'd0, 4'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
